// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: req/gnt/rvalid data bus master, pipeline stall and MEM/WB register.
// Optional build macro MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them down.
module mem_stage_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_m,
  input  logic              reg_write_m,
  input  logic              result_src_m,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [2:0]        funct3_m,
  input  logic [4:0]        rd_m,
  input  logic [31:0]       alu_result_m,
  input  logic [31:0]       write_data_m,
  input  logic [31:0]       pc_plus4_m,
  output logic              stall_o,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output logic              valid_w,
  output logic              reg_write_w,
  output logic              result_src_w,
  output logic [4:0]        rd_w,
  output logic [31:0]       pc_plus4_w,
  output logic [31:0]       alu_result_w,
  output logic [31:0]       read_data_w,
  output logic              misalign_o,
  output logic              bus_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t            state, state_next;
  logic [15:0]       to_cnt;
  logic              access, trap, timeout, load_done, req_c, stall_c, in_req;
  logic [ADDR_W-1:0] addr_now, addr_hold;
  logic [3:0]        be_now, be_hold;
  logic [31:0]       wdata_now, wdata_hold, load_data;
  logic              we_hold;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  assign access = valid_m & (mem_read_m | mem_write_m);

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  always_comb begin
    case (funct3_m[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = alu_result_m[0];
      default: misalign = |alu_result_m[1:0];
    endcase
  end
  assign trap = access & misalign;
`else
  assign trap = 1'b0;
`endif

  // Sub-word offsets only shape byte enables and lanes, so the bus address is always word aligned.
  assign addr_now = {alu_result_m[ADDR_W-1:2], 2'b00};

  always_comb begin
    case (funct3_m[1:0])
      2'b00: begin
        be_now    = 4'b0001 << alu_result_m[1:0];
        wdata_now = {4{write_data_m[7:0]}};
      end
      2'b01: begin
        be_now    = alu_result_m[1] ? 4'b1100 : 4'b0011;
        wdata_now = {2{write_data_m[15:0]}};
      end
      default: begin
        be_now    = 4'b1111;
        wdata_now = write_data_m;
      end
    endcase
  end

  assign lane_b = bus_rdata[{alu_result_m[1:0], 3'b000} +: 8];
  assign lane_h = alu_result_m[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    case (funct3_m)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_data = {24'h0, lane_b};
      3'b101:  load_data = {16'h0, lane_h};
      default: load_data = bus_rdata;
    endcase
  end

  // Rvalid in WAIT wins over a timeout that lands in the same cycle.
  assign timeout = (state != IDLE) && (to_cnt == TO_LAST) &&
                   !((state == WAIT) && bus_rvalid);

  always_comb begin
    state_next = state;
    req_c      = 1'b0;
    stall_c    = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (access && !trap) begin
          req_c      = 1'b1;
          stall_c    = 1'b1;
          state_next = bus_gnt ? WAIT : REQ;
        end
      end
      REQ: begin
        req_c = 1'b1;
        if (timeout) begin
          state_next = IDLE;
        end else begin
          stall_c = 1'b1;
          if (bus_gnt) state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          load_done  = 1'b1;
          state_next = IDLE;
        end else if (timeout) begin
          state_next = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus_req   = req_c & rst;
  assign stall_o   = stall_c & rst;
  assign in_req    = (state == REQ);
  assign bus_addr  = in_req ? addr_hold  : addr_now;
  assign bus_be    = in_req ? be_hold    : be_now;
  assign bus_wdata = in_req ? wdata_hold : wdata_now;
  assign bus_we    = in_req ? we_hold    : mem_write_m;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      to_cnt     <= 16'h0;
      addr_hold  <= '0;
      be_hold    <= 4'h0;
      wdata_hold <= 32'h0;
      we_hold    <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == IDLE) to_cnt <= 16'h0;
      else if (state != IDLE) to_cnt <= to_cnt + 16'h1;
      // Snapshot the request in IDLE so the bus stays stable while waiting for a grant.
      if (state == IDLE) begin
        addr_hold  <= addr_now;
        be_hold    <= be_now;
        wdata_hold <= wdata_now;
        we_hold    <= mem_write_m;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      result_src_w <= 1'b0;
      rd_w         <= 5'h0;
      pc_plus4_w   <= 32'h0;
      alu_result_w <= 32'h0;
      read_data_w  <= 32'h0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
    end else if (!stall_c) begin
      valid_w      <= valid_m;
      reg_write_w  <= reg_write_m & !timeout & !trap;
      result_src_w <= result_src_m;
      rd_w         <= rd_m;
      pc_plus4_w   <= pc_plus4_m;
      alu_result_w <= alu_result_m;
      read_data_w  <= (load_done && !mem_write_m) ? load_data : 32'h0;
      misalign_o   <= trap;
      bus_err_o    <= timeout;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end
  end
endmodule
